// File: rtl/rv_wb_pkg.sv
// Shared writeback types and helpers for the register bank write port.
// Index width, bank size and the x0 constant live here.
package rv_wb_pkg;

    localparam int XLEN      = 32;
    localparam int REG_IDX_W = 5;
    localparam int NUM_REGS  = 32;

    localparam logic [REG_IDX_W-1:0] REG_X0 = 5'd0;

    typedef struct packed {
        logic [REG_IDX_W-1:0] rd;
        logic [XLEN-1:0]      data;
    } wb_req_t;

    function automatic logic [NUM_REGS-1:0] onehot_rd(
        input logic [REG_IDX_W-1:0] idx
    );
        logic [NUM_REGS-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: scans from ptr+1 cyclically.
// Grant is one-hot plus its encoded index; empty when en is low.
module rr_arbiter #(
    parameter int N = 3
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    input  logic                 en,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] gnt_idx
);

    localparam int IW = $clog2(N);

    logic [IW-1:0] k;
    logic          found;

    // First requester after ptr, wrapping modulo N
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        k       = '0;
        if (en) begin
            for (int i = 1; i <= N; i++) begin
                k = IW'((int'(ptr) + i) % N);
                if (!found && req[k]) begin
                    found    = 1'b1;
                    gnt[k]   = 1'b1;
                    gnt_idx  = k;
                end
            end
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter for the single register bank write port.
// Registers the winner onto one-hot Load strobes and a shared D bus.
module regfile_wb_arbiter
    import rv_wb_pkg::*;
#(
    parameter int N_REQ    = 3,
    parameter int XLEN     = rv_wb_pkg::XLEN,
    parameter int NUM_REGS = rv_wb_pkg::NUM_REGS
) (
    input  logic                         Clk,
    input  logic                         Reset,
    input  logic                         Stall,
    input  logic [N_REQ-1:0]             req_valid,
    input  logic [N_REQ*REG_IDX_W-1:0]   req_rd,
    input  logic [N_REQ*XLEN-1:0]        req_data,
    output logic [N_REQ-1:0]             req_ready,
    output logic [NUM_REGS-1:0]          wb_load,
    output logic [XLEN-1:0]              wb_data,
    output logic [REG_IDX_W-1:0]         wb_rd,
    output logic                         wb_valid
);

    localparam int IW = $clog2(N_REQ);

    logic [IW-1:0]          rr_ptr;
    logic [N_REQ-1:0]       gnt;
    logic [IW-1:0]          gnt_idx;
    logic                   xfer;
    logic [REG_IDX_W-1:0]   sel_rd;
    logic [XLEN-1:0]        sel_data;
    logic                   sel_ok;
    logic [31:0]            sel_oh;

    rr_arbiter #(
        .N       (N_REQ)
    ) u_rr (
        .req     (req_valid),
        .ptr     (rr_ptr),
        .en      (~Stall & ~Reset),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    assign req_ready = gnt;
    assign xfer      = |gnt;

    // One-hot mux of the granted source's payload
    always_comb begin
        sel_rd   = '0;
        sel_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt[i]) begin
                sel_rd   = req_rd[i*REG_IDX_W +: REG_IDX_W];
                sel_data = req_data[i*XLEN +: XLEN];
            end
        end
        sel_ok = (sel_rd != REG_X0) && (int'(sel_rd) < NUM_REGS);
        sel_oh = onehot_rd(sel_rd);
    end

    // Output register and round-robin pointer
    always_ff @(posedge Clk) begin
        if (Reset) begin
            rr_ptr   <= IW'(N_REQ - 1);
            wb_load  <= '0;
            wb_data  <= '0;
            wb_rd    <= '0;
            wb_valid <= 1'b0;
        end else begin
            wb_load  <= '0;
            wb_valid <= 1'b0;
            if (xfer) begin
                rr_ptr  <= gnt_idx;
                wb_data <= sel_data;
                wb_rd   <= sel_rd;
                if (sel_ok) begin
                    wb_load  <= sel_oh[NUM_REGS-1:0];
                    wb_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed scenarios plus a
// randomized run against a cyclic-scan reference model.
module tb_regfile_wb_arbiter;
    import rv_wb_pkg::*;

    logic        Clk;
    logic        Reset;
    logic        Stall;
    logic [2:0]  req_valid;
    logic [14:0] req_rd;
    logic [95:0] req_data;
    logic [2:0]  req_ready;
    logic [31:0] wb_load;
    logic [31:0] wb_data;
    logic [4:0]  wb_rd;
    logic        wb_valid;

    wb_req_t src [3];

    int checks = 0;
    int errors = 0;
    logic mon_en = 1'b0;

    assign req_rd   = {src[2].rd, src[1].rd, src[0].rd};
    assign req_data = {src[2].data, src[1].data, src[0].data};

    regfile_wb_arbiter #(
        .N_REQ    (3),
        .XLEN     (32),
        .NUM_REGS (32)
    ) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .Stall     (Stall),
        .req_valid (req_valid),
        .req_rd    (req_rd),
        .req_data  (req_data),
        .req_ready (req_ready),
        .wb_load   (wb_load),
        .wb_data   (wb_data),
        .wb_rd     (wb_rd),
        .wb_valid  (wb_valid)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Sources must hold valid and payload until accepted
    logic [2:0] pv, pr;
    wb_req_t    ps [3];
    always @(posedge Clk) begin
        for (int i = 0; i < 3; i++) begin
            if (mon_en && pv[i] && !pr[i]) begin
                checks++;
                if (!req_valid[i] || src[i] !== ps[i]) begin
                    errors++;
                    $display("FAIL hold src%0d: valid %b req %h prev %h",
                             i, req_valid[i], src[i], ps[i]);
                end
            end
            ps[i] = src[i];
        end
        pv = Reset ? 3'b000 : req_valid;
        pr = req_ready;
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic set_src(input int s, input logic [4:0] rd,
                           input logic [31:0] d);
        src[s].rd   = rd;
        src[s].data = d;
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        Stall = 1'b0;
        req_valid = 3'b111;
        set_src(0, 5'd1, 32'h11);
        set_src(1, 5'd2, 32'h22);
        set_src(2, 5'd3, 32'h33);
        tick();
        tick();
        checks++;
        if (req_ready !== 3'b000 || wb_load !== 32'h0 ||
            wb_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset: ready %b load %h valid %b",
                     req_ready, wb_load, wb_valid);
        end
        checks++;
        if (wb_data !== 32'h0 || wb_rd !== 5'd0) begin
            errors++;
            $display("FAIL reset_bus: data %h rd %0d", wb_data, wb_rd);
        end
        Reset = 1'b0;
        #1;
        checks++;
        if (req_ready !== 3'b001) begin
            errors++;
            $display("FAIL first_grant: ready %b want 001", req_ready);
        end
        tick();
        req_valid = 3'b000;
        checks++;
        if (wb_load !== 32'h2 || wb_data !== 32'h11) begin
            errors++;
            $display("FAIL first_write: load %h data %h want 2/11",
                     wb_load, wb_data);
        end
        tick();
    endtask

    task automatic test_single();
        req_valid = 3'b010;
        set_src(1, 5'd5, 32'hDEADBEEF);
        #1;
        checks++;
        if (req_ready !== 3'b010) begin
            errors++;
            $display("FAIL single_ready: ready %b want 010", req_ready);
        end
        tick();
        req_valid = 3'b000;
        checks++;
        if (wb_load !== 32'h20 || wb_data !== 32'hDEADBEEF ||
            wb_valid !== 1'b1 || wb_rd !== 5'd5) begin
            errors++;
            $display("FAIL single_wb: load %h data %h valid %b rd %0d",
                     wb_load, wb_data, wb_valid, wb_rd);
        end
        tick();
        checks++;
        if (wb_load !== 32'h0 || wb_valid !== 1'b0 ||
            wb_data !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL single_after: load %h valid %b data %h",
                     wb_load, wb_valid, wb_data);
        end
    endtask

    task automatic test_contention();
        logic [2:0]  er;
        logic [31:0] el;
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        set_src(0, 5'd1, 32'hA0);
        set_src(1, 5'd2, 32'hA1);
        set_src(2, 5'd3, 32'hA2);
        req_valid = 3'b111;
        for (int i = 0; i < 6; i++) begin
            er = 3'b001 << (i % 3);
            el = 32'h2 << (i % 3);
            #1;
            checks++;
            if (req_ready !== er) begin
                errors++;
                $display("FAIL rr_ready[%0d]: ready %b want %b",
                         i, req_ready, er);
            end
            tick();
            checks++;
            if (wb_load !== el || $countones(wb_load) > 1) begin
                errors++;
                $display("FAIL rr_load[%0d]: load %h want %h",
                         i, wb_load, el);
            end
        end
        req_valid = 3'b000;
        tick();
    endtask

    task automatic test_x0();
        req_valid = 3'b100;
        set_src(2, 5'd0, 32'h12345678);
        #1;
        checks++;
        if (req_ready !== 3'b100) begin
            errors++;
            $display("FAIL x0_ready: ready %b want 100", req_ready);
        end
        tick();
        req_valid = 3'b000;
        checks++;
        if (wb_load !== 32'h0 || wb_valid !== 1'b0 ||
            wb_data !== 32'h12345678 || wb_rd !== 5'd0) begin
            errors++;
            $display("FAIL x0_wb: load %h valid %b data %h rd %0d",
                     wb_load, wb_valid, wb_data, wb_rd);
        end
    endtask

    task automatic test_stall();
        set_src(0, 5'd1, 32'hB0);
        set_src(1, 5'd2, 32'hB1);
        set_src(2, 5'd3, 32'hB2);
        req_valid = 3'b111;
        #1;
        checks++;
        if (req_ready !== 3'b001) begin
            errors++;
            $display("FAIL stall_pre: ready %b want 001", req_ready);
        end
        tick();
        req_valid = 3'b110;
        Stall = 1'b1;
        checks++;
        if (wb_load !== 32'h2 || wb_data !== 32'hB0) begin
            errors++;
            $display("FAIL stall_inflight: load %h data %h",
                     wb_load, wb_data);
        end
        for (int j = 0; j < 3; j++) begin
            #1;
            checks++;
            if (req_ready !== 3'b000) begin
                errors++;
                $display("FAIL stall_ready[%0d]: ready %b want 000",
                         j, req_ready);
            end
            tick();
            checks++;
            if (wb_load !== 32'h0) begin
                errors++;
                $display("FAIL stall_load[%0d]: load %h want 0",
                         j, wb_load);
            end
        end
        Stall = 1'b0;
        #1;
        checks++;
        if (req_ready !== 3'b010) begin
            errors++;
            $display("FAIL stall_resume: ready %b want 010", req_ready);
        end
        tick();
        req_valid = 3'b100;
        checks++;
        if (wb_load !== 32'h4) begin
            errors++;
            $display("FAIL stall_resume_wb: load %h want 4", wb_load);
        end
        tick();
        req_valid = 3'b000;
        checks++;
        if (wb_load !== 32'h8) begin
            errors++;
            $display("FAIL stall_src2_wb: load %h want 8", wb_load);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        set_src(1, 5'd7, 32'hC1);
        req_valid = 3'b010;
        #1;
        checks++;
        if (req_ready !== 3'b010) begin
            errors++;
            $display("FAIL rmid_ready: ready %b want 010", req_ready);
        end
        tick();
        Reset = 1'b1;
        set_src(0, 5'd9, 32'hC0);
        req_valid = 3'b111;
        #1;
        checks++;
        if (req_ready !== 3'b000) begin
            errors++;
            $display("FAIL rmid_held: ready %b want 000", req_ready);
        end
        tick();
        checks++;
        if (wb_load !== 32'h0 || wb_valid !== 1'b0) begin
            errors++;
            $display("FAIL rmid_flush: load %h valid %b",
                     wb_load, wb_valid);
        end
        Reset = 1'b0;
        #1;
        checks++;
        if (req_ready !== 3'b001) begin
            errors++;
            $display("FAIL rmid_first: ready %b want 001", req_ready);
        end
        tick();
        req_valid = 3'b000;
        checks++;
        if (wb_load !== 32'h200 || wb_data !== 32'hC0) begin
            errors++;
            $display("FAIL rmid_wb: load %h data %h want 200/C0",
                     wb_load, wb_data);
        end
        tick();
    endtask

    task automatic test_random();
        int          last;
        int          g;
        int          s;
        logic [2:0]  er;
        logic [31:0] el;
        logic [31:0] ed;
        logic [4:0]  erd;
        logic        ev;
        Reset = 1'b1;
        req_valid = 3'b000;
        Stall = 1'b0;
        tick();
        Reset = 1'b0;
        last = 2;
        ed = 32'h0;
        erd = 5'd0;
        mon_en = 1'b1;
        for (int c = 0; c < 400; c++) begin
            for (int k = 0; k < 3; k++) begin
                if (!req_valid[k] && $urandom_range(2) == 0) begin
                    req_valid[k] = 1'b1;
                    src[k].rd = 5'($urandom_range(31));
                    if ($urandom_range(7) == 0) src[k].rd = 5'd0;
                    src[k].data = $urandom;
                end
            end
            Stall = ($urandom_range(4) == 0);
            #1;
            g = -1;
            if (!Stall) begin
                for (int i = 1; i <= 3; i++) begin
                    s = (last + i) % 3;
                    if (g < 0 && req_valid[s]) g = s;
                end
            end
            er = (g < 0) ? 3'b000 : 3'(1 << g);
            checks++;
            if (req_ready !== er) begin
                errors++;
                $display("FAIL rnd_ready[%0d]: ready %b want %b",
                         c, req_ready, er);
            end
            tick();
            if (g >= 0) begin
                last = g;
                ed = src[g].data;
                erd = src[g].rd;
                ev = (erd != 5'd0);
                el = ev ? (32'h1 << erd) : 32'h0;
                req_valid[g] = 1'b0;
            end else begin
                ev = 1'b0;
                el = 32'h0;
            end
            checks++;
            if (wb_load !== el || wb_valid !== ev) begin
                errors++;
                $display("FAIL rnd_load[%0d]: load %h valid %b want %h %b",
                         c, wb_load, wb_valid, el, ev);
            end
            checks++;
            if (wb_data !== ed || wb_rd !== erd) begin
                errors++;
                $display("FAIL rnd_bus[%0d]: data %h rd %0d want %h %0d",
                         c, wb_data, wb_rd, ed, erd);
            end
        end
        mon_en = 1'b0;
        Stall = 1'b0;
        req_valid = 3'b000;
        tick();
    endtask

    initial begin
        Reset = 1'b1;
        Stall = 1'b0;
        req_valid = 3'b000;
        for (int i = 0; i < 3; i++) set_src(i, 5'd0, 32'h0);
        test_reset();
        test_single();
        test_contention();
        test_x0();
        test_stall();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
